// File: rtl/stim_pkg.sv
// Shared definitions for the exhaustive-stimulus generator/checker pair.
// Both ends import STIM_WIDTH so they agree on the vector width.
package stim_pkg;

    localparam int STIM_WIDTH = 2;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } state_t;

endpackage

// File: rtl/stim_cover_map.sv
// Coverage bitmap of the 2^WIDTH stimulus combinations with a distinct-hit
// counter and a sticky done flag; clear restarts coverage.
module stim_cover_map #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             hit,
    input  logic [WIDTH-1:0] idx,
    output logic [WIDTH:0]   cover_cnt,
    output logic             done
);
    localparam int             DEPTH  = 1 << WIDTH;
    localparam logic [WIDTH:0] FULL_C = (WIDTH+1)'(DEPTH);

    logic [DEPTH-1:0] bitmap_r;
    logic [DEPTH-1:0] bitmap_n_s;
    logic [WIDTH:0]   cnt_r;
    logic [WIDTH:0]   cnt_n_s;
    logic             done_r;
    logic             done_n_s;
    logic             new_hit_s;

    // Next-state coverage: only a first hit on a combination advances the count
    always_comb begin
        bitmap_n_s = bitmap_r;
        cnt_n_s    = cnt_r;
        done_n_s   = done_r;
        new_hit_s  = hit & ~bitmap_r[idx];
        if (clear) begin
            bitmap_n_s = {DEPTH{1'b0}};
            cnt_n_s    = {(WIDTH+1){1'b0}};
            done_n_s   = 1'b0;
        end else if (new_hit_s) begin
            bitmap_n_s[idx] = 1'b1;
            cnt_n_s         = cnt_r + (WIDTH+1)'(1);
            done_n_s        = done_r | (cnt_n_s == FULL_C);
        end else begin
            done_n_s = done_r;
        end
    end

    // Coverage state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_r <= {DEPTH{1'b0}};
            cnt_r    <= {(WIDTH+1){1'b0}};
            done_r   <= 1'b0;
        end else begin
            bitmap_r <= bitmap_n_s;
            cnt_r    <= cnt_n_s;
            done_r   <= done_n_s;
        end
    end

    assign cover_cnt = cnt_r;
    assign done      = done_r;

endmodule

// File: rtl/stimulus_checker.sv
// Receive end of the counting stimulus interface: verifies the +1 modulo
// 2^WIDTH order, counts violations and tracks combination coverage.
module stimulus_checker
    import stim_pkg::*;
#(
    parameter int WIDTH = STIM_WIDTH,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             clear,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH:0]   cover_cnt,
    output logic             done
);
    localparam logic [ERR_W-1:0] ERR_MAX_C = {ERR_W{1'b1}};

    state_t           state_r;
    state_t           state_n_s;
    logic             locked_r;
    logic             locked_n_s;
    logic [WIDTH-1:0] expected_r;
    logic [WIDTH-1:0] expected_n_s;
    logic             err_pulse_r;
    logic             err_pulse_n_s;
    logic [ERR_W-1:0] err_cnt_r;
    logic [ERR_W-1:0] err_cnt_n_s;
    logic             hit_s;

    // Sequence FSM: first sample becomes the reference, later ones must count up
    always_comb begin
        state_n_s     = state_r;
        locked_n_s    = locked_r;
        expected_n_s  = expected_r;
        err_pulse_n_s = 1'b0;
        err_cnt_n_s   = err_cnt_r;
        if (clear) begin
            state_n_s    = HUNT;
            locked_n_s   = 1'b0;
            expected_n_s = {WIDTH{1'b0}};
            err_cnt_n_s  = {ERR_W{1'b0}};
        end else if (in_valid) begin
            case (state_r)
                HUNT: begin
                    state_n_s    = CHECK;
                    locked_n_s   = 1'b1;
                    expected_n_s = in_vec + WIDTH'(1);
                end
                CHECK: begin
                    if (in_vec == expected_r) begin
                        expected_n_s = expected_r + WIDTH'(1);
                    end else begin
                        // Resync on the offending sample so one glitch costs one error
                        err_pulse_n_s = 1'b1;
                        expected_n_s  = in_vec + WIDTH'(1);
                        if (err_cnt_r != ERR_MAX_C) begin
                            err_cnt_n_s = err_cnt_r + ERR_W'(1);
                        end else begin
                            err_cnt_n_s = err_cnt_r;
                        end
                    end
                end
                default: begin
                    state_n_s  = HUNT;
                    locked_n_s = 1'b0;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // FSM and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            locked_r    <= 1'b0;
            expected_r  <= {WIDTH{1'b0}};
            err_pulse_r <= 1'b0;
            err_cnt_r   <= {ERR_W{1'b0}};
        end else begin
            state_r     <= state_n_s;
            locked_r    <= locked_n_s;
            expected_r  <= expected_n_s;
            err_pulse_r <= err_pulse_n_s;
            err_cnt_r   <= err_cnt_n_s;
        end
    end

    assign hit_s = in_valid & ~clear;

    stim_cover_map #(
        .WIDTH (WIDTH)
    ) u_cover_map (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .hit       (hit_s),
        .idx       (in_vec),
        .cover_cnt (cover_cnt),
        .done      (done)
    );

    assign locked    = locked_r;
    assign expected  = expected_r;
    assign err_pulse = err_pulse_r;
    assign err_cnt   = err_cnt_r;

endmodule
